uart_mmio_fifo: RTL and testbench
=================================

Name: uart_mmio_fifo

Overview:
Memory-mapped UART interface for the RISC-V core that adds TX and RX FIFOs between the CPU load/store port and the UART transmitter/receiver. Byte widths and FIFO depths are parameters. It also provides a status register, a sticky RX overflow flag, FIFO flush and a level interrupt. It sits on the core's MMIO decode path at BASE_ADDR, with one-cycle registered read data to match data-memory timing.

Parameters:
BASE_ADDR, 32'h8000_0000, MMIO base; block decodes when addr[31:8] == BASE_ADDR[31:8]
DATA_W, 8, UART character width (1..8)
TX_DEPTH, 8, TX FIFO entries (2..255, power of two)
RX_DEPTH, 8, RX FIFO entries (2..255, power of two)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
addr  in  32  byte address from the memory stage
din  in  32  store data
wbe  in  4  byte write enables; store when != 0
re  in  1  load strobe from the memory stage (decoded load)
dout  out  32  registered read data, valid the cycle after re
irq  out  1  level interrupt
data_in  out  DATA_W  TX FIFO head to the UART transmitter
data_in_valid  out  1  TX FIFO not empty
data_in_ready  in  1  transmitter accepts data_in
data_out  in  DATA_W  byte from the UART receiver
data_out_valid  in  1  receiver byte valid
data_out_ready  out  1  tied to 1; the serial line cannot stall

Behaviour:
- Register map, offset = addr[7:0]:
  - 0x00 STATUS (RO): [0] tx_not_full, [1] rx_not_empty, [2] rx_overflow, [3] tx_empty, [15:8] tx_count, [23:16] rx_count, other bits 0.
  - 0x04 RXDATA (RO): a read pops RX.
  - 0x08 TXDATA (WO): a write pushes din[DATA_W-1:0].
  - 0x0C IEN (RW): [0] rx_not_empty, [1] tx_empty, [2] rx_overflow.
  - 0x10 CMD (WO, self-clearing): [0] flush TX, [1] flush RX, [2] clear rx_overflow.
  - Unmapped offset or no decode: reads return 0 and writes are ignored.
- Writes act on clk rise when decode && wbe != 0. TXDATA and CMD require wbe[0]; IEN uses wbe[0] for bits [2:0].
- Read path: when decode && re, dout is registered on the clk edge. When re is 0, dout holds its value.
  - An RXDATA read with the FIFO not empty gives dout = {0, head} and pops at the same edge.
  - An RXDATA read with the FIFO empty gives dout = 0, with no pop and no flag change.
  - A STATUS read reflects state before that edge's updates.
- TX FIFO:
  - Push on TXDATA write when not full; a write while full is silently dropped.
  - Pop when data_in_valid && data_in_ready. data_in is the head, combinational from storage.
  - Push and pop in the same cycle: both take effect and the count is unchanged, including when full (the push is accepted because a pop frees a slot).
- RX FIFO:
  - Push when data_out_valid. A push while full with no simultaneous pop drops the byte and sets rx_overflow (sticky).
  - Push and pop in the same cycle while full: both succeed, no overflow.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits, zero-extended into STATUS.
- Flush: the CMD write resets that FIFO's pointers and count at that edge. A same-cycle push to the flushed FIFO is discarded. Flush TX deasserts data_in_valid the next cycle.
- Clear of rx_overflow wins over a same-cycle overflow event.
- irq = (IEN[0] & rx_not_empty) | (IEN[1] & tx_empty) | (IEN[2] & rx_overflow), combinational from registers.
- Reset (rst_n low, asynchronous): both FIFOs empty, rx_overflow = 0, IEN = 0, dout = 0, data_in_valid = 0, irq = 0, data_out_ready = 1.
  - Reset mid-transfer discards all queued bytes; storage contents are don't-care.

Test Plan:
- Reset, then read STATUS (addr 8000_0000, re=1) -> dout = 32'h0000_0009 (tx_not_full, tx_empty); data_in_valid = 0; irq = 0.
- Hold data_in_ready=0 and store 0x41..0x48 to 8000_0008 with wbe=0001, then store 0x49 -> STATUS = 32'h0000_0800; 0x49 is dropped. Release data_in_ready -> data_in shows 0x41..0x48 in order, then data_in_valid = 0.
- Pulse data_out_valid with 0x67 -> next-cycle STATUS bit1 = 1 and rx_count = 1. Read 8000_0004 -> dout = 32'h0000_0067; a second read -> dout = 0, rx_count stays 0.
- Push 9 bytes into RX with no reads -> rx_overflow = 1 and rx_count = 8. Write IEN = 4 -> irq = 1. Write CMD = 4 -> rx_overflow = 0 and irq = 0 next cycle. Repeat with a full RX plus a same-cycle pop and push -> no overflow.
- Full TX, then a same-cycle TXDATA write and transmitter pop -> tx_count stays 8 and the new byte is emitted last. Write CMD = 1 -> tx_count = 0 and data_in_valid = 0.
- Assert rst_n low mid-cycle with both FIFOs partially filled -> outputs return to reset values immediately, without waiting for clk; STATUS afterwards = 32'h0000_0009.

Source files
------------

// File: rtl/uart_mmio_fifo.sv
// MMIO UART front end: TX/RX FIFOs behind a small register file on the core's
// load/store port, with a sticky RX overflow flag, FIFO flush and a level irq.
module uart_mmio_fifo #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          DATA_W    = 8,
   parameter int          TX_DEPTH  = 8,
   parameter int          RX_DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       addr,
   input  logic [31:0]       din,
   input  logic [3:0]        wbe,
   input  logic              re,
   output logic [31:0]       dout,
   output logic              irq,
   output logic [DATA_W-1:0] data_in,
   output logic              data_in_valid,
   input  logic              data_in_ready,
   input  logic [DATA_W-1:0] data_out,
   input  logic              data_out_valid,
   output logic              data_out_ready
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int TX_CW = TX_AW + 1;
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int RX_CW = RX_AW + 1;

   localparam logic [7:0] OFF_STATUS = 8'h00;
   localparam logic [7:0] OFF_RXDATA = 8'h04;
   localparam logic [7:0] OFF_TXDATA = 8'h08;
   localparam logic [7:0] OFF_IEN    = 8'h0C;
   localparam logic [7:0] OFF_CMD    = 8'h10;

   logic [DATA_W-1:0] r_tx_mem [TX_DEPTH];
   logic [TX_AW-1:0]  r_tx_wp, r_tx_rp;
   logic [TX_CW-1:0]  r_tx_cnt;
   logic [DATA_W-1:0] r_rx_mem [RX_DEPTH];
   logic [RX_AW-1:0]  r_rx_wp, r_rx_rp;
   logic [RX_CW-1:0]  r_rx_cnt;
   logic              r_rx_ovf;
   logic [2:0]        r_ien;
   logic [31:0]       r_dout;

   logic        w_dec, w_wr0, w_rd;
   logic [7:0]  w_off;
   logic        w_tx_wr, w_cmd, w_flush_tx, w_flush_rx, w_clr_ovf;
   logic        w_tx_full, w_tx_empty, w_tx_pop, w_tx_push;
   logic        w_rx_full, w_rx_empty, w_rx_pop, w_rx_push, w_ovf_evt;
   logic [DATA_W-1:0] w_rx_head;
   logic [31:0] w_status, w_rdata;
   logic        w_unused_ok;

   assign w_dec      = (addr[31:8] == BASE_ADDR[31:8]);
   assign w_off      = addr[7:0];
   assign w_wr0      = w_dec && wbe[0];
   assign w_rd       = w_dec && re;
   assign w_tx_wr    = w_wr0 && (w_off == OFF_TXDATA);
   assign w_cmd      = w_wr0 && (w_off == OFF_CMD);
   assign w_flush_tx = w_cmd && din[0];
   assign w_flush_rx = w_cmd && din[1];
   assign w_clr_ovf  = w_cmd && din[2];

   // A push into a full FIFO is still accepted when the same edge pops a slot free.
   assign w_tx_full  = (r_tx_cnt == TX_CW'(TX_DEPTH));
   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_tx_pop   = !w_tx_empty && data_in_ready;
   assign w_tx_push  = w_tx_wr && (!w_tx_full || w_tx_pop) && !w_flush_tx;

   assign w_rx_full  = (r_rx_cnt == RX_CW'(RX_DEPTH));
   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_rx_pop   = w_rd && (w_off == OFF_RXDATA) && !w_rx_empty;
   assign w_rx_push  = data_out_valid && (!w_rx_full || w_rx_pop) && !w_flush_rx;
   assign w_ovf_evt  = data_out_valid && w_rx_full && !w_rx_pop;
   assign w_rx_head  = r_rx_mem[r_rx_rp];

   assign w_unused_ok = ^{din, wbe};

   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= din[DATA_W-1:0];
      if (w_rx_push) r_rx_mem[r_rx_wp] <= data_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else if (w_flush_tx) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + TX_AW'(1);
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_AW'(1);
         if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + TX_CW'(1);
         else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - TX_CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else if (w_flush_rx) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + RX_AW'(1);
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_AW'(1);
         if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + RX_CW'(1);
         else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - RX_CW'(1);
      end
   end

   // Clearing the flag takes priority over an overflow on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_ovf <= 1'b0;
         r_ien    <= '0;
      end else begin
         if (w_clr_ovf)      r_rx_ovf <= 1'b0;
         else if (w_ovf_evt) r_rx_ovf <= 1'b1;
         if (w_wr0 && (w_off == OFF_IEN)) r_ien <= din[2:0];
      end
   end

   assign w_status = {8'h00, 8'(r_rx_cnt), 8'(r_tx_cnt), 4'h0,
                      w_tx_empty, r_rx_ovf, !w_rx_empty, !w_tx_full};

   always_comb begin
      w_rdata = '0;
      case (w_off)
         OFF_STATUS: w_rdata = w_status;
         OFF_RXDATA: if (!w_rx_empty) w_rdata = 32'(w_rx_head);
         OFF_IEN:    w_rdata = {29'd0, r_ien};
         default:    w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_dout <= '0;
      else if (w_rd) r_dout <= w_rdata;
   end

   assign dout           = r_dout;
   assign data_in        = r_tx_mem[r_tx_rp];
   assign data_in_valid  = !w_tx_empty;
   assign data_out_ready = 1'b1;
   assign irq = (r_ien[0] & !w_rx_empty) | (r_ien[1] & w_tx_empty) | (r_ien[2] & r_rx_ovf);

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo: register map, FIFO boundaries, overflow,
// flush, interrupt and asynchronous reset.
module tb_uart_mmio_fifo;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr, din;
   logic [3:0]  wbe;
   logic        re;
   logic [31:0] dout;
   logic        irq;
   logic [7:0]  data_in;
   logic        data_in_valid, data_in_ready;
   logic [7:0]  data_out;
   logic        data_out_valid, data_out_ready;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] rd;

   uart_mmio_fifo dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .wbe(wbe), .re(re),
      .dout(dout), .irq(irq), .data_in(data_in), .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready), .data_out(data_out),
      .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; din = d; wbe = 4'b0001;
      tick();
      wbe = 4'b0000;
   endtask

   task automatic rd_reg(input logic [31:0] a, output logic [31:0] q);
      addr = a; re = 1'b1;
      tick();
      re = 1'b0;
      q = dout;
   endtask

   task automatic rx_push(input logic [7:0] b);
      data_out = b; data_out_valid = 1'b1;
      tick();
      data_out_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; addr = BASE; din = '0; wbe = '0; re = 1'b0;
      data_in_ready = 1'b0; data_out = '0; data_out_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_dout", dout, 32'h0);
      check("reset_valid", 32'(data_in_valid), 32'h0);
      check("reset_irq", 32'(irq), 32'h0);
      check("reset_out_ready", 32'(data_out_ready), 32'h1);
      rst_n = 1'b1;
      tick();
      rd_reg(BASE + 32'h00, rd); check("status_after_reset", rd, 32'h0000_0009);

      // Fill TX with the transmitter stalled, then overfill by one.
      for (int i = 0; i < 8; i++) wr(BASE + 32'h08, 32'h41 + 32'(i));
      wr(BASE + 32'h08, 32'h49);
      rd_reg(BASE + 32'h00, rd); check("status_tx_full", rd, 32'h0000_0800);
      data_in_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("tx_drain_valid", 32'(data_in_valid), 32'h1);
         check("tx_drain_data", 32'(data_in), 32'h41 + 32'(i));
         tick();
      end
      check("tx_drained_valid", 32'(data_in_valid), 32'h0);
      data_in_ready = 1'b0;

      // Unmapped offset, foreign address, IEN readback.
      rd_reg(BASE + 32'h20, rd); check("unmapped_read", rd, 32'h0);
      wr(32'h9000_0008, 32'h55);
      rd_reg(BASE + 32'h00, rd); check("foreign_write_ignored", rd, 32'h0000_0009);
      wr(BASE + 32'h0C, 32'h2);
      check("irq_tx_empty", 32'(irq), 32'h1);
      rd_reg(BASE + 32'h0C, rd); check("ien_readback", rd, 32'h2);
      wr(BASE + 32'h0C, 32'h0);
      check("irq_ien_off", 32'(irq), 32'h0);

      // Single RX byte, then read from an empty FIFO.
      rx_push(8'h67);
      rd_reg(BASE + 32'h00, rd); check("status_rx_one", rd, 32'h0001_000B);
      rd_reg(BASE + 32'h04, rd); check("rx_read_67", rd, 32'h0000_0067);
      rd_reg(BASE + 32'h04, rd); check("rx_read_empty", rd, 32'h0);
      rd_reg(BASE + 32'h00, rd); check("status_rx_empty", rd, 32'h0000_0009);

      // Overflow RX by one byte.
      for (int i = 0; i < 9; i++) rx_push(8'h10 + 8'(i));
      rd_reg(BASE + 32'h00, rd); check("status_rx_ovf", rd, 32'h0008_000F);
      check("irq_ovf_masked", 32'(irq), 32'h0);
      wr(BASE + 32'h0C, 32'h4);
      check("irq_ovf", 32'(irq), 32'h1);
      wr(BASE + 32'h10, 32'h4);
      check("irq_ovf_cleared", 32'(irq), 32'h0);
      rd_reg(BASE + 32'h00, rd); check("status_ovf_cleared", rd, 32'h0008_000B);

      // Full RX: pop and push on the same edge must not overflow.
      data_out = 8'h20; data_out_valid = 1'b1;
      rd_reg(BASE + 32'h04, rd);
      data_out_valid = 1'b0;
      check("rx_pop_push_head", rd, 32'h10);
      rd_reg(BASE + 32'h00, rd); check("status_pop_push", rd, 32'h0008_000B);

      // Overflow and clear on the same edge: clear wins.
      data_out = 8'h99; data_out_valid = 1'b1;
      wr(BASE + 32'h10, 32'h4);
      data_out_valid = 1'b0;
      rd_reg(BASE + 32'h00, rd); check("status_clear_wins", rd, 32'h0008_000B);
      for (int i = 0; i < 7; i++) begin
         rd_reg(BASE + 32'h04, rd); check("rx_drain", rd, 32'h11 + 32'(i));
      end
      rd_reg(BASE + 32'h04, rd); check("rx_drain_last", rd, 32'h20);
      rd_reg(BASE + 32'h00, rd); check("status_rx_drained", rd, 32'h0000_0009);
      wr(BASE + 32'h0C, 32'h0);

      // Full TX with a same-edge write and transmitter pop.
      for (int i = 0; i < 8; i++) wr(BASE + 32'h08, 32'h50 + 32'(i));
      data_in_ready = 1'b1;
      wr(BASE + 32'h08, 32'h58);
      data_in_ready = 1'b0;
      check("tx_head_after_pp", 32'(data_in), 32'h51);
      rd_reg(BASE + 32'h00, rd); check("status_tx_pp", rd, 32'h0000_0800);
      data_in_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("tx_pp_data", 32'(data_in), 32'h51 + 32'(i));
         tick();
      end
      check("tx_pp_drained", 32'(data_in_valid), 32'h0);
      data_in_ready = 1'b0;

      // Flush TX and RX.
      for (int i = 0; i < 3; i++) wr(BASE + 32'h08, 32'h60 + 32'(i));
      wr(BASE + 32'h10, 32'h1);
      check("flush_tx_valid", 32'(data_in_valid), 32'h0);
      rd_reg(BASE + 32'h00, rd); check("status_flush_tx", rd, 32'h0000_0009);
      rx_push(8'h71); rx_push(8'h72);
      data_out = 8'h73; data_out_valid = 1'b1;
      wr(BASE + 32'h10, 32'h2);
      data_out_valid = 1'b0;
      rd_reg(BASE + 32'h00, rd); check("status_flush_rx", rd, 32'h0000_0009);

      // Asynchronous reset between edges with both FIFOs partly filled.
      wr(BASE + 32'h08, 32'h80); wr(BASE + 32'h08, 32'h81);
      rx_push(8'h31); rx_push(8'h32);
      rd_reg(BASE + 32'h04, rd); check("pre_reset_rx", rd, 32'h31);
      wr(BASE + 32'h0C, 32'h1);
      check("pre_reset_irq", 32'(irq), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_dout", dout, 32'h0);
      check("async_irq", 32'(irq), 32'h0);
      check("async_valid", 32'(data_in_valid), 32'h0);
      check("async_out_ready", 32'(data_out_ready), 32'h1);
      tick();
      rst_n = 1'b1;
      tick();
      rd_reg(BASE + 32'h00, rd); check("status_after_async", rd, 32'h0000_0009);
      rd_reg(BASE + 32'h0C, rd); check("ien_after_async", rd, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
